fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_en  input  1  permits starting new frames; sampled only in IDLE.
REQ-006 fifo_empty  input  1  empty flag from the upstream synchronous FIFO.
REQ-007 fifo_data  input  8  FIFO read data, valid the cycle after a read_en pulse.
REQ-008 fifo_read_en  output  1  one-cycle pop strobe to the FIFO.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-012 FSM states SHALL be IDLE, READ, LOAD, START, DATA, STOP.
REQ-013 IDLE -> READ when tx_en=1 and fifo_empty=0; otherwise remain in IDLE.
REQ-014 READ SHALL last exactly one cycle with fifo_read_en=1, then go to LOAD.
REQ-015 fifo_read_en SHALL be 0 in every state other than READ; the block SHALL never pop more than one byte per frame.
REQ-016 LOAD SHALL last one cycle and capture fifo_data into the 8-bit shift register at its closing edge, then go to START.
REQ-017 START, each DATA bit and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles.
REQ-018 tx SHALL be 0 in START, shift_reg[0] in DATA (LSB first, 8 bits), and 1 in STOP, IDLE, READ and LOAD.
REQ-019 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; bit index SHALL count 0..7.
REQ-020 STOP -> IDLE at the end of the stop bit; frame length from the first START cycle = 10*CLKS_PER_BIT cycles.
REQ-021 Back-to-back frames: the minimum tx-high gap between a stop bit's end and the next start SHALL be exactly 3 cycles (IDLE, READ, LOAD).
REQ-022 tx_en and fifo_empty changes outside IDLE SHALL be ignored; an in-progress frame always completes.
REQ-023 The block SHALL NOT inspect FIFO full; upstream overflow is out of scope.

Reset
REQ-024 With reset=1 at a rising edge: state=IDLE, tx=1, busy=0, fifo_read_en=0, frame_done=0, counters=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the following cycle and the popped byte is discarded.
REQ-026 Reset SHALL take precedence over every other input in the same cycle.

Structure
REQ-027 A shared package fifo_uart_pkg SHALL hold the state encoding constants and the CLKS_PER_BIT default.
REQ-028 The bit-period counter SHALL be a sub-module uart_baud_gen (inputs clk, reset, clear; output bit_tick).
REQ-029 Counter widths SHALL be derived from CLKS_PER_BIT with $clog2, with no hard-coded widths.
REQ-030 The target implementation size is 120-400 lines of RTL, registered outputs only.

Verification (CLKS_PER_BIT=4)
REQ-031 Single byte: FIFO holds 0xA5 and tx_en=1 -> one fifo_read_en pulse; tx = 0 then 1,0,1,0,0,1,0,1 then 1, each 4 cycles; frame_done pulses once after 40 cycles.
REQ-032 Back-to-back: FIFO holds 0x55 then 0x0F -> two frames; tx high for exactly 7 cycles between them (stop bit plus 3); two read_en pulses.
REQ-033 Empty FIFO: fifo_empty=1 for 100 cycles with tx_en=1 -> tx=1, busy=0, fifo_read_en=0 throughout.
REQ-034 tx_en drop: tx_en to 0 in the 3rd DATA bit with bytes pending -> current frame completes; no further read_en; busy=0 after STOP.
REQ-035 Mid-frame reset: reset pulse during the 5th DATA bit -> next cycle tx=1, busy=0; once reset clears, a fresh frame starts with a new pop.
REQ-036 Bench SHALL assert that fifo_read_en never occurs while fifo_empty=1.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// frame geometry and the default bit period.
package fifo_uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS        = 8;
  localparam int BIT_IDX_W        = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and raises a registered
// bit_tick during the last cycle of every bit period.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // bit_tick is set one cycle ahead so it is high exactly while cnt is at its last value
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else if (bit_tick) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt      <= cnt + 1'b1;
      bit_tick <= (cnt == PRE_LAST);
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one byte per frame from a synchronous FIFO
// and sends it 8N1, LSB first.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_read_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);
  state_t                 state, state_nxt;
  logic [DATA_BITS-1:0]   shift_reg, shift_nxt;
  logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic                   bit_tick;
  logic                   baud_clear;

  // Hold the counter at zero until the frame starts so START gets a full period
  assign baud_clear = (state == ST_IDLE) || (state == ST_READ) || (state == ST_LOAD);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_idx_nxt = bit_idx;
    case (state)
      ST_IDLE:  if (tx_en && !fifo_empty) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_LOAD;
      ST_LOAD: begin
        shift_nxt   = fifo_data;
        bit_idx_nxt = '0;
        state_nxt   = ST_START;
      end
      ST_START: if (bit_tick) state_nxt = ST_DATA;
      ST_DATA: if (bit_tick) begin
        shift_nxt   = shift_reg >> 1;
        bit_idx_nxt = bit_idx + 1'b1;
        if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) state_nxt = ST_STOP;
      end
      ST_STOP:  if (bit_tick) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx      <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      fifo_read_en <= 1'b0;
    end else begin
      state        <= state_nxt;
      shift_reg    <= shift_nxt;
      bit_idx      <= bit_idx_nxt;
      tx           <= (state_nxt == ST_START) ? 1'b0 :
                      (state_nxt == ST_DATA)  ? shift_nxt[0] : 1'b1;
      busy         <= (state_nxt != ST_IDLE);
      fifo_read_en <= (state_nxt == ST_READ);
    end
  end

  assign frame_done = (state == ST_STOP) && bit_tick;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds bytes, a line
// monitor decodes frames from tx and compares them against expected bytes.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_en, tx, busy, frame_done;

  int n_chk = 0, n_err = 0, cyc = 0, rd_cnt = 0, last_end = -1, n_abort = 0;
  bit gap_chk = 1'b0;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous FIFO model: data appears the cycle after a pop
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_en && fq.size() != 0) begin
      fifo_data <= fq[0];
      fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (fifo_read_en) begin
      rd_cnt++;
      chk("read_while_empty", 32'(fifo_empty), 32'd0);
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_it);
    fq.push_back(b);
    if (expect_it) exp_q.push_back(b);
  endtask

  // Called on the negedge where tx is first seen low
  task automatic decode_frame();
    logic [9:0] bits;
    logic       stable, fd_last, aborted;
    int         fd_cnt;
    bits = '0; stable = 1'b1; fd_last = 1'b0; aborted = 1'b0; fd_cnt = 0;
    if (gap_chk && last_end >= 0) chk("b2b_gap", 32'(cyc - last_end - 1), 32'd3);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (reset) begin aborted = 1'b1; break; end
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) stable = 1'b0;
        if (frame_done) begin
          fd_cnt++;
          fd_last = (b == 9 && c == CPB - 1);
        end
      end
      if (aborted) break;
    end
    if (aborted) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      n_abort++;
      last_end = -1;
    end else begin
      chk("start_bit", 32'(bits[0]), 32'd0);
      chk("stop_bit", 32'(bits[9]), 32'd1);
      chk("bit_stable", 32'(stable), 32'd1);
      chk("frame_done_cnt", 32'(fd_cnt), 32'd1);
      chk("frame_done_pos", 32'(fd_last), 32'd1);
      if (exp_q.size() == 0) chk("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
      else chk("frame_byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
      last_end = cyc;
    end
  endtask

  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) decode_frame();
    end
  end

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || busy) && n < budget);
    if (exp_q.size() != 0 || busy) chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_tx_low(input int budget, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < budget);
    if (tx !== 1'b0) chk({tag, "_start_timeout"}, 32'(tx), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin : stim
    int r0, viol;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_en", 32'(fifo_read_en), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // single byte
    r0 = rd_cnt; tx_en = 1'b1;
    push(8'hA5, 1'b1);
    wait_drain(200, "single");
    chk("single_reads", 32'(rd_cnt - r0), 32'd1);

    // back-to-back frames
    @(posedge clk); #1;
    r0 = rd_cnt; last_end = -1; gap_chk = 1'b1;
    push(8'h55, 1'b1); push(8'h0F, 1'b1);
    wait_drain(300, "b2b");
    gap_chk = 1'b0;
    chk("b2b_reads", 32'(rd_cnt - r0), 32'd2);

    // empty FIFO with tx_en held
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_en !== 1'b0) viol++;
    end
    chk("empty_idle_viol", 32'(viol), 32'd0);

    // tx_en dropped mid-frame with bytes still queued
    @(posedge clk); #1;
    r0 = rd_cnt;
    push(8'h3C, 1'b1); push(8'h99, 1'b0); push(8'h12, 1'b0);
    wait_tx_low(100, "drop");
    repeat (13) @(negedge clk);
    @(posedge clk); #1 tx_en = 1'b0;
    @(negedge clk);
    chk("drop_still_busy", 32'(busy), 32'd1);
    wait_drain(200, "drop");
    repeat (30) @(negedge clk);
    chk("drop_reads", 32'(rd_cnt - r0), 32'd1);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_tx", 32'(tx), 32'd1);
    @(posedge clk); #1 fq.delete();
    repeat (2) @(posedge clk);
    #1 tx_en = 1'b1;

    // reset in the 5th data bit
    r0 = rd_cnt;
    push(8'hC3, 1'b1);
    wait_tx_low(100, "mid_rst");
    repeat (21) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_read_en", 32'(fifo_read_en), 32'd0);
    chk("mid_rst_abort_seen", 32'(n_abort), 32'd1);
    chk("mid_rst_reads", 32'(rd_cnt - r0), 32'd1);
    @(posedge clk); #1;
    r0 = rd_cnt;
    push(8'h7E, 1'b1);
    wait_drain(200, "fresh");
    chk("fresh_reads", 32'(rd_cnt - r0), 32'd1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
